or4_event_qualifier: RTL and testbench
======================================

// Module: or4_event_qualifier
// PURPOSE
// - Downstream consumer of a 4-input OR wake/request tree (A1..A4 -> Z).
// - Synchronizes four async request lines, OR-reduces them, glitch-filters the result,
//   and holds a sticky pending flag plus captured source bits until the consumer acknowledges.
// - Sits between raw pad/cell request nets and the MCU wake/interrupt controller.
// PARAMETERS
// - SYNC_STAGES  2  synchronizer flops per input, legal 1..3
// - FILT_CYC     3  consecutive synced-high cycles that qualify an event, legal 1..15
// PORTS
// - CLK   input  1  single clock, all state on rising edge
// - RN    input  1  reset, synchronous, active-low
// - A1    input  1  async request source 1
// - A2    input  1  async request source 2
// - A3    input  1  async request source 3
// - A4    input  1  async request source 4
// - ACK   input  1  consumer acknowledge, one-cycle pulse or level
// - Z     output 1  qualified event pending (sticky)
// - SRC   output 4  captured sources {A4,A3,A2,A1}, valid while Z=1
// - BUSY  output 1  FSM not in IDLE
// - VDD   inout  1  power, no functional effect
// - VSS   inout  1  ground, no functional effect
// BEHAVIOUR
// - Reset: edge with RN=0 clears sync flops, cnt, SRC, Z=0, BUSY=0, state=IDLE.
//   RN overrides everything, including mid-PEND; a pending event is dropped.
// - s[3:0] = last sync stage; ev = |s.
// - cnt width 4, saturates at FILT_CYC, clears whenever ev=0.
// - FSM states:
//   IDLE:     ev=1 -> FILTER with cnt=1; if FILT_CYC=1 -> PEND directly.
//   FILTER:   ev=0 -> IDLE, cnt=0.
//             cnt+1==FILT_CYC -> PEND: Z<=1, SRC<=s.
//   PEND:     Z=1; SRC<=SRC|s each cycle (sticky accumulate).
//             ACK=1 -> Z<=0, SRC<=0; next = WAIT_REL if ev=1, else IDLE.
//   WAIT_REL: ev=0 -> IDLE; no re-trigger while any source stays high.
// - Latency: A held high from edge 1 -> s high after edge SYNC_STAGES;
//   Z high after edge SYNC_STAGES+FILT_CYC (defaults: edge 5).
// - ACK outside PEND is ignored. ACK coincident with a new source rising in PEND:
//   ACK wins, new bit not captured, FSM -> WAIT_REL.
// - Pulse shorter than FILT_CYC synced cycles: no Z, FSM returns to IDLE.
// - BUSY=1 in FILTER, PEND and WAIT_REL.
// - Outputs are registered, no combinational path from inputs to outputs.
// CONFIGURATION
// - GF180MCU_OR4_MASK_EN defined:
//   - adds input MASK[3:0], synchronous config; MASK[i]=1 disables source i.
//   - masking applies after the synchronizer: ev = |(s & ~MASK); SRC captures s & ~MASK.
//   - a MASK change takes effect on the next edge.
// - GF180MCU_OR4_MASK_EN undefined: no MASK port; all four sources always enabled.
// TESTING
// - Reset: RN=0 for 2 edges with A1..A4=1 -> Z=0, SRC=0, BUSY=0; RN=1 -> Z=1 after edge 5.
// - Qualify: A3=1 from edge 1, defaults -> Z=1 after edge 5, SRC=4'b0100;
//   ACK at edge 8 with A3 still 1 -> Z=0, WAIT_REL; A3=0 -> IDLE; no re-trigger.
// - Glitch: A1 high 2 cycles, FILT_CYC=3 -> Z stays 0, BUSY returns to 0.
// - Accumulate: A2 qualifies, A4 rises during PEND -> SRC=4'b1010 before ACK;
//   ACK -> SRC=0.
// - Reset mid-PEND: Z=1, RN=0 for 1 edge -> Z=0, SRC=0, state IDLE.
// - Mask (macro defined): MASK=4'b0001, A1=1 -> Z never rises;
//   A1=1 and A2=1 -> SRC=4'b0010.

Source files
------------

// File: rtl/or4_event_qualifier.sv
// Qualifies a 4-input OR request tree: synchronize, OR-reduce, glitch-filter, sticky pending + source capture.
// Optional source masking is enabled by defining GF180MCU_OR4_MASK_EN (adds the MASK[3:0] input).
module or4_event_qualifier #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 3
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       A1,
  input  logic       A2,
  input  logic       A3,
  input  logic       A4,
  input  logic       ACK,
`ifdef GF180MCU_OR4_MASK_EN
  input  logic [3:0] MASK,
`endif
  output logic       Z,
  output logic [3:0] SRC,
  output logic       BUSY,
  inout  wire        VDD,
  inout  wire        VSS
);

  localparam int unsigned SRC_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILTER   = 2'd1,
    ST_PEND     = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_e;

  state_e                              state_q, state_d;
  logic [SYNC_STAGES-1:0][SRC_W-1:0]   sync_q, sync_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [SRC_W-1:0]                    src_q, src_d;
  logic                                z_q, z_d;
  logic                                busy_q, busy_d;

  logic [SRC_W-1:0] a_raw;
  logic [SRC_W-1:0] s_m;
  logic             ev;
  logic             unused_pwr;

  // Supply pins are carried for netlist compatibility only.
  assign unused_pwr = VDD ^ VSS;

  assign a_raw = {A4, A3, A2, A1};

`ifdef GF180MCU_OR4_MASK_EN
  assign s_m = sync_q[SYNC_STAGES-1] & ~MASK;
`else
  assign s_m = sync_q[SYNC_STAGES-1];
`endif

  assign ev = |s_m;

  // Synchronizer shift, filter counter and FSM next-state/output logic.
  always_comb begin
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    src_d   = src_q;
    z_d     = z_q;

    sync_d[0] = a_raw;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end

    // Counter saturates at FILT_CYC and clears whenever the OR is low.
    if (!ev) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_W'(FILT_CYC)) begin
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ev) begin
          if (FILT_CYC == 1) begin
            state_d = ST_PEND;
            z_d     = 1'b1;
            src_d   = s_m;
          end else begin
            state_d = ST_FILTER;
          end
        end
      end
      ST_FILTER: begin
        if (!ev) begin
          state_d = ST_IDLE;
        end else if (CNT_W'(cnt_q + CNT_W'(1)) == CNT_W'(FILT_CYC)) begin
          state_d = ST_PEND;
          z_d     = 1'b1;
          src_d   = s_m;
        end
      end
      ST_PEND: begin
        // ACK takes priority over any source newly seen this cycle.
        if (ACK) begin
          z_d     = 1'b0;
          src_d   = '0;
          state_d = ev ? ST_WAIT_REL : ST_IDLE;
        end else begin
          z_d   = 1'b1;
          src_d = src_q | s_m;
        end
      end
      ST_WAIT_REL: begin
        if (!ev) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      cnt_q   <= '0;
      src_q   <= '0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
    end
  end

  assign Z    = z_q;
  assign SRC  = src_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_or4_event_qualifier.sv
// Directed bench for or4_event_qualifier at default parameters (SYNC_STAGES=2, FILT_CYC=3).
// Mask checks run only when GF180MCU_OR4_MASK_EN is defined.
module tb_or4_event_qualifier;

  logic       clk;
  logic       rn;
  logic       a1, a2, a3, a4;
  logic       ack;
  logic       z;
  logic [3:0] src;
  logic       busy;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;
`ifdef GF180MCU_OR4_MASK_EN
  logic [3:0] mask;
`endif

  int checks = 0;
  int errors = 0;

  or4_event_qualifier dut (
    .CLK  (clk),
    .RN   (rn),
    .A1   (a1),
    .A2   (a2),
    .A3   (a3),
    .A4   (a4),
    .ACK  (ack),
`ifdef GF180MCU_OR4_MASK_EN
    .MASK (mask),
`endif
    .Z    (z),
    .SRC  (src),
    .BUSY (busy),
    .VDD  (vdd),
    .VSS  (vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ez, input logic [3:0] esrc, input logic ebusy);
    chk({tag, ".z"},    {3'b000, z},    {3'b000, ez});
    chk({tag, ".src"},  src,            esrc);
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, ebusy});
  endtask

  initial begin
    rn = 1'b0; ack = 1'b0;
    {a4, a3, a2, a1} = 4'b1111;
`ifdef GF180MCU_OR4_MASK_EN
    mask = 4'b0000;
`endif
    #1;

    // Reset held 2 edges with all sources high, then release.
    tick(2);
    chk_out("reset", 1'b0, 4'h0, 1'b0);
    rn = 1'b1;
    tick(2);
    chk_out("rst_rel_e2", 1'b0, 4'h0, 1'b0);
    tick(2);
    chk_out("rst_rel_e4", 1'b0, 4'h0, 1'b1);
    tick(1);
    chk_out("rst_rel_e5", 1'b1, 4'hF, 1'b1);
    {a4, a3, a2, a1} = 4'b0000;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk_out("rst_ack", 1'b0, 4'h0, 1'b1);
    tick(2);
    chk_out("rst_drain", 1'b0, 4'h0, 1'b0);
    tick(2);

    // Qualify A3, ACK at edge 8 while A3 held: no re-trigger.
    a3 = 1'b1;
    tick(4);
    chk_out("q_e4", 1'b0, 4'h0, 1'b1);
    tick(1);
    chk_out("q_e5", 1'b1, 4'h4, 1'b1);
    tick(2);
    chk_out("q_e7", 1'b1, 4'h4, 1'b1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk_out("q_ack", 1'b0, 4'h0, 1'b1);
    tick(4);
    chk_out("q_waitrel", 1'b0, 4'h0, 1'b1);
    a3 = 1'b0;
    tick(3);
    chk_out("q_release", 1'b0, 4'h0, 1'b0);
    tick(5);
    chk_out("q_noretrig", 1'b0, 4'h0, 1'b0);

    // Glitch: A1 high for 2 cycles never qualifies.
    a1 = 1'b1;
    tick(2);
    a1 = 1'b0;
    tick(1);
    chk_out("gl_filter", 1'b0, 4'h0, 1'b1);
    tick(2);
    chk_out("gl_idle", 1'b0, 4'h0, 1'b0);
    tick(3);
    chk_out("gl_quiet", 1'b0, 4'h0, 1'b0);

    // Accumulate: A2 qualifies, A4 joins during PEND.
    a2 = 1'b1;
    tick(5);
    chk_out("acc_pend", 1'b1, 4'h2, 1'b1);
    a4 = 1'b1;
    tick(2);
    chk_out("acc_lag", 1'b1, 4'h2, 1'b1);
    tick(1);
    chk_out("acc_merge", 1'b1, 4'hA, 1'b1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk_out("acc_ack", 1'b0, 4'h0, 1'b1);
    {a4, a2} = 2'b00;
    tick(3);
    chk_out("acc_idle", 1'b0, 4'h0, 1'b0);

    // ACK asserted during FILTER is ignored.
    a1 = 1'b1;
    tick(3);
    ack = 1'b1;
    tick(1);
    chk_out("fack_filter", 1'b0, 4'h0, 1'b1);
    ack = 1'b0;
    tick(1);
    chk_out("fack_pend", 1'b1, 4'h1, 1'b1);

    // Reset mid-PEND drops the event.
    rn = 1'b0;
    tick(1);
    chk_out("rst_pend", 1'b0, 4'h0, 1'b0);
    rn = 1'b1;
    a1 = 1'b0;
    tick(4);
    chk_out("rst_pend_after", 1'b0, 4'h0, 1'b0);

`ifdef GF180MCU_OR4_MASK_EN
    // Masked source never triggers; unmasked source captured alone.
    mask = 4'b0001;
    a1 = 1'b1;
    tick(8);
    chk_out("mask_a1", 1'b0, 4'h0, 1'b0);
    a2 = 1'b1;
    tick(5);
    chk_out("mask_a2", 1'b1, 4'h2, 1'b1);
    {a2, a1} = 2'b00;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(3);
    chk_out("mask_idle", 1'b0, 4'h0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
